// File: rtl/mem_stage_lsu_if.sv
// Signal bundle between the MEM-stage LSU, the EX/MEM and MEM/WB pipeline registers, and the data bus.
// The master modport is the LSU's view of the bundle; the slave modport is the view from the pipeline and bus side.
interface mem_stage_lsu_if;
  logic        ex_valid;
  logic [63:0] ex_pc;
  logic [31:0] ex_inst;
  logic [63:0] ex_alu_result;
  logic [63:0] ex_wdata;
  logic        ex_mem_re;
  logic        ex_mem_we;
  logic [1:0]  ex_mem_size;
  logic        ex_mem_unsigned;
  logic [1:0]  ex_sel_rfres;
  logic        ex_rf_we;
  logic [4:0]  ex_rf_waddr;
  logic        ex_sys;

  logic [63:0] mem_pc;
  logic [31:0] mem_inst;
  logic [63:0] mem_alu_result;
  logic [63:0] mem_rdata;
  logic [1:0]  mem_sel_rfres;
  logic        mem_rf_we;
  logic [4:0]  mem_rf_waddr;
  logic        mem_sys;
  logic        mem_valid;
  logic        mem_stall;

  logic        dbus_req;
  logic        dbus_we;
  logic [63:0] dbus_addr;
  logic [63:0] dbus_wdata;
  logic [7:0]  dbus_wmask;
  logic        dbus_gnt;
  logic        dbus_rvalid;
  logic [63:0] dbus_rdata;

  modport master (
    input  ex_valid, ex_pc, ex_inst, ex_alu_result, ex_wdata, ex_mem_re, ex_mem_we,
           ex_mem_size, ex_mem_unsigned, ex_sel_rfres, ex_rf_we, ex_rf_waddr, ex_sys,
           dbus_gnt, dbus_rvalid, dbus_rdata,
    output mem_pc, mem_inst, mem_alu_result, mem_rdata, mem_sel_rfres, mem_rf_we,
           mem_rf_waddr, mem_sys, mem_valid, mem_stall,
           dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_wmask
  );

  modport slave (
    output ex_valid, ex_pc, ex_inst, ex_alu_result, ex_wdata, ex_mem_re, ex_mem_we,
           ex_mem_size, ex_mem_unsigned, ex_sel_rfres, ex_rf_we, ex_rf_waddr, ex_sys,
           dbus_gnt, dbus_rvalid, dbus_rdata,
    input  mem_pc, mem_inst, mem_alu_result, mem_rdata, mem_sel_rfres, mem_rf_we,
           mem_rf_waddr, mem_sys, mem_valid, mem_stall,
           dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_wmask
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: req/gnt/rvalid data-bus handshake, load alignment/extension, zero-latency pass-through.
// Optional MISALIGN_TRAP_EN: misaligned accesses skip the bus and are flagged on mem_misalign in DONE.
module mem_stage_lsu #(
  parameter logic [63:0] RESET_PC    = 64'h8000_0000,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic            clk,
  input  logic            rst,
  mem_stage_lsu_if.master io,
  output logic            bus_timeout
`ifdef MISALIGN_TRAP_EN
  ,
  output logic            mem_misalign
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, alu_q, wdata_q, rdata_q;
  logic [31:0] inst_q;
  logic [1:0]  size_q, sel_q;
  logic [4:0]  waddr_q;
  logic        re_q, we_q, uns_q, rf_we_q, sys_q, abort_q, mis_q, timeout_q;

  logic        ex_mem, accept, trap_accept, capture, timeout_hit, is_load;
  logic [2:0]  lane;
  logic [7:0]  size_mask;
  logic [63:0] raw, load_data;
  logic        sign;

  assign ex_mem  = io.ex_mem_re | io.ex_mem_we;
  assign accept  = (state_q == IDLE) && io.ex_valid && ex_mem;
  assign lane    = alu_q[2:0];
  assign is_load = re_q && !we_q;
  assign capture = io.dbus_rvalid && is_load &&
                   (((state_q == REQ) && io.dbus_gnt) || (state_q == WAIT));

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  always_comb begin
    unique case (io.ex_mem_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = io.ex_alu_result[0];
      2'd2:    misaligned = |io.ex_alu_result[1:0];
      default: misaligned = |io.ex_alu_result[2:0];
    endcase
  end
  assign trap_accept  = accept && misaligned;
  assign mem_misalign = (state_q == DONE) && mis_q;
`else
  assign trap_accept = 1'b0;
`endif

  // WAIT cycle counter; rvalid in the final allowed cycle still wins over the abort.
  generate
    if (TIMEOUT_CYC == 0) begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end else begin : g_timeout
      localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);
      logic [CW-1:0] cnt_q;
      always_ff @(posedge clk) begin
        if (rst || (state_q != WAIT)) cnt_q <= '0;
        else                          cnt_q <= cnt_q + CW'(1);
      end
      assign timeout_hit = (state_q == WAIT) && !io.dbus_rvalid && (cnt_q == LAST);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = trap_accept ? DONE : REQ;
      REQ:     if (io.dbus_gnt) state_d = io.dbus_rvalid ? DONE : WAIT;
      WAIT:    if (io.dbus_rvalid || timeout_hit) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      alu_q     <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      inst_q    <= '0;
      size_q    <= '0;
      sel_q     <= '0;
      waddr_q   <= '0;
      re_q      <= 1'b0;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      rf_we_q   <= 1'b0;
      sys_q     <= 1'b0;
      abort_q   <= 1'b0;
      mis_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (accept) begin
        pc_q    <= io.ex_pc;
        alu_q   <= io.ex_alu_result;
        wdata_q <= io.ex_wdata;
        rdata_q <= '0;
        inst_q  <= io.ex_inst;
        size_q  <= io.ex_mem_size;
        sel_q   <= io.ex_sel_rfres;
        waddr_q <= io.ex_rf_waddr;
        re_q    <= io.ex_mem_re;
        we_q    <= io.ex_mem_we;
        uns_q   <= io.ex_mem_unsigned;
        rf_we_q <= io.ex_rf_we;
        sys_q   <= io.ex_sys;
        abort_q <= 1'b0;
        mis_q   <= trap_accept;
      end
      if (capture) rdata_q <= io.dbus_rdata;
      if (timeout_hit) begin
        abort_q   <= 1'b1;
        timeout_q <= 1'b1;
      end
    end
  end

  assign bus_timeout = timeout_q;

  always_comb begin
    unique case (size_q)
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  end

  // Zero fill from the right shift drops bytes beyond lane 7.
  always_comb begin
    raw       = rdata_q >> {lane, 3'b000};
    sign      = 1'b0;
    load_data = raw;
    unique case (size_q)
      2'd0: begin
        sign      = !uns_q && raw[7];
        load_data = {{56{sign}}, raw[7:0]};
      end
      2'd1: begin
        sign      = !uns_q && raw[15];
        load_data = {{48{sign}}, raw[15:0]};
      end
      2'd2: begin
        sign      = !uns_q && raw[31];
        load_data = {{32{sign}}, raw[31:0]};
      end
      default: load_data = raw;
    endcase
  end

  always_comb begin
    io.mem_pc         = RESET_PC;
    io.mem_inst       = '0;
    io.mem_alu_result = '0;
    io.mem_rdata      = '0;
    io.mem_sel_rfres  = '0;
    io.mem_rf_we      = 1'b0;
    io.mem_rf_waddr   = '0;
    io.mem_sys        = 1'b0;
    io.mem_valid      = 1'b0;
    io.mem_stall      = 1'b0;
    io.dbus_req       = 1'b0;
    io.dbus_we        = 1'b0;
    io.dbus_addr      = '0;
    io.dbus_wdata     = '0;
    io.dbus_wmask     = '0;
    if (state_q == IDLE) begin
      if (io.ex_valid && ex_mem) begin
        io.mem_stall = 1'b1;
      end else if (io.ex_valid) begin
        io.mem_pc         = io.ex_pc;
        io.mem_inst       = io.ex_inst;
        io.mem_alu_result = io.ex_alu_result;
        io.mem_sel_rfres  = io.ex_sel_rfres;
        io.mem_rf_we      = io.ex_rf_we;
        io.mem_rf_waddr   = io.ex_rf_waddr;
        io.mem_sys        = io.ex_sys;
        io.mem_valid      = 1'b1;
      end
    end else begin
      io.mem_pc         = pc_q;
      io.mem_inst       = inst_q;
      io.mem_alu_result = alu_q;
      io.mem_sel_rfres  = sel_q;
      io.mem_rf_waddr   = waddr_q;
      io.mem_sys        = sys_q;
      case (state_q)
        REQ: begin
          io.mem_stall  = 1'b1;
          io.dbus_req   = 1'b1;
          io.dbus_we    = we_q;
          io.dbus_addr  = {alu_q[63:3], 3'b000};
          io.dbus_wdata = wdata_q << {lane, 3'b000};
          io.dbus_wmask = size_mask << lane;
        end
        WAIT: io.mem_stall = 1'b1;
        default: begin
          io.mem_valid = 1'b1;
          io.mem_rf_we = rf_we_q && !abort_q && !mis_q;
          io.mem_rdata = (is_load && !abort_q && !mis_q) ? load_data : '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: pass-through vector table, directed bus sequences,
// and randomized loads/stores checked against a byte-level reference model.
module tb_mem_stage_lsu;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;
  localparam int          TO       = 4;

  logic clk = 1'b0;
  logic rst;
  logic bus_timeout;
`ifdef MISALIGN_TRAP_EN
  logic mem_misalign;
`endif

  int    n_checks  = 0;
  int    n_err     = 0;
  string cur_tag   = "reset";
  logic  bto_model = 1'b0;
  logic [63:0] last_rdata, last_wdata, last_addr;
  logic [7:0]  last_wmask;
  logic        last_rfwe, last_we;

  mem_stage_lsu_if io();

  mem_stage_lsu #(.RESET_PC(RESET_PC), .TIMEOUT_CYC(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .io          (io),
    .bus_timeout (bus_timeout)
`ifdef MISALIGN_TRAP_EN
    ,
    .mem_misalign(mem_misalign)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s/%s: got %h expected %h", cur_tag, name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model: byte-level view of a 64-bit little-endian bus word.
  function automatic logic [63:0] ref_load(input logic [63:0] word, input int lane, input int nb, input logic uns);
    logic [63:0] r = '0;
    for (int b = 0; b < nb; b++)
      if (lane + b < 8) r[8*b +: 8] = word[8*(lane+b) +: 8];
    if (!uns && nb < 8 && r[8*nb-1])
      for (int b = nb; b < 8; b++) r[8*b +: 8] = 8'hFF;
    return r;
  endfunction

  function automatic logic [7:0] ref_wmask(input int lane, input int nb);
    logic [7:0] m = '0;
    for (int b = 0; b < nb; b++)
      if (lane + b < 8) m[lane+b] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] ref_wdata(input logic [63:0] wd, input int lane);
    logic [63:0] r = '0;
    for (int i = lane; i < 8; i++) r[8*i +: 8] = wd[8*(i-lane) +: 8];
    return r;
  endfunction

  task automatic clear_inputs();
    io.ex_valid = 1'b0;        io.ex_pc = '0;           io.ex_inst = '0;
    io.ex_alu_result = '0;     io.ex_wdata = '0;        io.ex_mem_re = 1'b0;
    io.ex_mem_we = 1'b0;       io.ex_mem_size = '0;     io.ex_mem_unsigned = 1'b0;
    io.ex_sel_rfres = '0;      io.ex_rf_we = 1'b0;      io.ex_rf_waddr = '0;
    io.ex_sys = 1'b0;          io.dbus_gnt = 1'b0;      io.dbus_rvalid = 1'b0;
    io.dbus_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    next_cycle();
    next_cycle();
    rst = 1'b0;
    bto_model = 1'b0;
  endtask

  // One load/store: gd cycles without gnt in REQ, then gnt; rvd=0 -> rvalid with gnt,
  // else rvalid in WAIT cycle rvd-1 (abandoned if that lies at or past TO).
  task automatic do_mem(input logic is_ld, input logic [1:0] size, input logic uns, input logic [63:0] addr,
                        input logic [63:0] wd, input logic [63:0] rd, input int gd, input int rvd);
    int          lane   = int'(addr[2:0]);
    int          nb     = 1 << size;
    logic        to_exp = (rvd > TO);
    logic [63:0] pc     = {$urandom, $urandom};
    logic [31:0] inst   = $urandom;
    logic [4:0]  wa     = 5'($urandom);
    logic [63:0] exp_rd = (is_ld && !to_exp) ? ref_load(rd, lane, nb, uns) : 64'h0;
    int          waits  = to_exp ? TO : rvd;

    io.ex_valid = 1'b1;      io.ex_pc = pc;           io.ex_inst = inst;
    io.ex_alu_result = addr; io.ex_wdata = wd;        io.ex_mem_re = is_ld;
    io.ex_mem_we = !is_ld;   io.ex_mem_size = size;   io.ex_mem_unsigned = uns;
    io.ex_sel_rfres = 2'd1;  io.ex_rf_we = is_ld;     io.ex_rf_waddr = wa;
    io.ex_sys = 1'b0;        io.dbus_gnt = 1'b0;      io.dbus_rvalid = 1'b0;
    @(negedge clk);
    chk("accept_stall", io.mem_stall, 1'b1);
    chk("accept_valid", io.mem_valid, 1'b0);
    chk("accept_req", io.dbus_req, 1'b0);
    next_cycle();

    for (int k = 0; k <= gd; k++) begin
      io.dbus_gnt    = (k == gd);
      io.dbus_rvalid = (k == gd) && (rvd == 0);
      io.dbus_rdata  = io.dbus_rvalid ? rd : {$urandom, $urandom};
      @(negedge clk);
      chk("req", io.dbus_req, 1'b1);
      chk("req_stall", io.mem_stall, 1'b1);
      chk("req_addr", io.dbus_addr, addr & ~64'h7);
      chk("req_we", io.dbus_we, !is_ld);
      chk("req_wmask", io.dbus_wmask, ref_wmask(lane, nb));
      chk("req_wdata", io.dbus_wdata, ref_wdata(wd, lane));
      last_addr = io.dbus_addr; last_wmask = io.dbus_wmask;
      last_wdata = io.dbus_wdata; last_we = io.dbus_we;
      next_cycle();
    end
    io.dbus_gnt = 1'b0;
    io.dbus_rvalid = 1'b0;

    if (rvd > 0) begin
      for (int w = 0; w < waits; w++) begin
        io.dbus_rvalid = (w == rvd - 1);
        io.dbus_rdata  = io.dbus_rvalid ? rd : {$urandom, $urandom};
        @(negedge clk);
        chk("wait_req", io.dbus_req, 1'b0);
        chk("wait_stall", io.mem_stall, 1'b1);
        chk("wait_valid", io.mem_valid, 1'b0);
        next_cycle();
      end
      io.dbus_rvalid = 1'b0;
    end

    if (to_exp) bto_model = 1'b1;
    io.dbus_rdata = {$urandom, $urandom};
    @(negedge clk);
    chk("done_valid", io.mem_valid, 1'b1);
    chk("done_stall", io.mem_stall, 1'b0);
    chk("done_req", io.dbus_req, 1'b0);
    chk("done_rdata", io.mem_rdata, exp_rd);
    chk("done_rf_we", io.mem_rf_we, is_ld && !to_exp);
    chk("done_alu", io.mem_alu_result, addr);
    chk("done_pc", io.mem_pc, pc);
    chk("done_inst", io.mem_inst, inst);
    chk("done_waddr", io.mem_rf_waddr, wa);
    chk("done_timeout", bus_timeout, bto_model);
    last_rdata = io.mem_rdata;
    last_rfwe  = io.mem_rf_we;
    $display("txn %s: %s size=%0d uns=%0d addr=%h gnt_dly=%0d rv_dly=%0d rdata=%h wmask=%h timeout=%0d",
             cur_tag, is_ld ? "LD" : "ST", size, uns, addr, gd, rvd, last_rdata, last_wmask, to_exp);
    next_cycle();
    io.ex_valid = 1'b0;
  endtask

  typedef struct {
    logic        v;
    logic [63:0] pc;
    logic [31:0] inst;
    logic [63:0] alu;
    logic [1:0]  sel;
    logic        rfwe;
    logic [4:0]  wa;
    logic        sys;
    logic        e_valid;
    logic [63:0] e_pc;
    logic [31:0] e_inst;
    logic [63:0] e_alu;
    logic [1:0]  e_sel;
    logic        e_rfwe;
    logic [4:0]  e_wa;
    logic        e_sys;
  } pt_vec_t;

  pt_vec_t pt[5];

  initial begin
    pt[0] = '{1'b1, 64'h8000_0100, 32'h0020_81B3, 64'h1234, 2'd0, 1'b1, 5'd3, 1'b0,
              1'b1, 64'h8000_0100, 32'h0020_81B3, 64'h1234, 2'd0, 1'b1, 5'd3, 1'b0};
    pt[1] = '{1'b0, 64'hDEAD_BEEF_0000_1111, 32'hFFFF_FFFF, 64'h5555, 2'd3, 1'b1, 5'd9, 1'b1,
              1'b0, RESET_PC, 32'h0, 64'h0, 2'd0, 1'b0, 5'd0, 1'b0};
    pt[2] = '{1'b1, 64'h8000_0104, 32'h0000_0073, 64'h0, 2'd2, 1'b0, 5'd0, 1'b1,
              1'b1, 64'h8000_0104, 32'h0000_0073, 64'h0, 2'd2, 1'b0, 5'd0, 1'b1};
    pt[3] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'hA5A5_5A5A, 64'hFFFF_FFFF_FFFF_FFFF, 2'd1, 1'b1, 5'd31, 1'b0,
              1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'hA5A5_5A5A, 64'hFFFF_FFFF_FFFF_FFFF, 2'd1, 1'b1, 5'd31, 1'b0};
    pt[4] = '{1'b0, 64'h1, 32'h1, 64'h1, 2'd1, 1'b1, 5'd1, 1'b1,
              1'b0, RESET_PC, 32'h0, 64'h0, 2'd0, 1'b0, 5'd0, 1'b0};

    do_reset();
    @(negedge clk);
    chk("valid", io.mem_valid, 1'b0);
    chk("stall", io.mem_stall, 1'b0);
    chk("req", io.dbus_req, 1'b0);
    chk("timeout", bus_timeout, 1'b0);
    chk("pc", io.mem_pc, RESET_PC);
    chk("alu", io.mem_alu_result, 64'h0);
`ifdef MISALIGN_TRAP_EN
    chk("misalign", mem_misalign, 1'b0);
`endif
    next_cycle();

    cur_tag = "passthru";
    for (int i = 0; i < 5; i++) begin
      io.ex_valid = pt[i].v;         io.ex_pc = pt[i].pc;        io.ex_inst = pt[i].inst;
      io.ex_alu_result = pt[i].alu;  io.ex_sel_rfres = pt[i].sel; io.ex_rf_we = pt[i].rfwe;
      io.ex_rf_waddr = pt[i].wa;     io.ex_sys = pt[i].sys;
      io.ex_mem_re = 1'b0;           io.ex_mem_we = 1'b0;         io.ex_wdata = {$urandom, $urandom};
      @(negedge clk);
      chk("valid", io.mem_valid, pt[i].e_valid);
      chk("stall", io.mem_stall, 1'b0);
      chk("req", io.dbus_req, 1'b0);
      chk("pc", io.mem_pc, pt[i].e_pc);
      chk("inst", io.mem_inst, pt[i].e_inst);
      chk("alu", io.mem_alu_result, pt[i].e_alu);
      chk("sel", io.mem_sel_rfres, pt[i].e_sel);
      chk("rf_we", io.mem_rf_we, pt[i].e_rfwe);
      chk("waddr", io.mem_rf_waddr, pt[i].e_wa);
      chk("sys", io.mem_sys, pt[i].e_sys);
      chk("rdata", io.mem_rdata, 64'h0);
      $display("txn passthru %0d: valid=%0d alu=%h pc=%h", i, io.mem_valid, io.mem_alu_result, io.mem_pc);
      next_cycle();
    end
    clear_inputs();

    cur_tag = "lb";
    do_mem(1'b1, 2'd0, 1'b0, 64'h8000_0003, 64'h0, 64'h0000_0000_8000_0000, 2, 3);
    chk("lb_rdata", last_rdata, 64'hFFFF_FFFF_FFFF_FF80);

    cur_tag = "sh";
    do_mem(1'b0, 2'd1, 1'b0, 64'h8000_0006, 64'hBEEF, 64'h1234_5678_9ABC_DEF0, 0, 1);
    chk("sh_wmask", last_wmask, 8'hC0);
    chk("sh_wdata", last_wdata, 64'hBEEF_0000_0000_0000);
    chk("sh_addr", last_addr, 64'h8000_0000);
    chk("sh_we", last_we, 1'b1);
    chk("sh_rdata", last_rdata, 64'h0);

    cur_tag = "lwu";
    do_mem(1'b1, 2'd2, 1'b1, 64'h8000_0004, 64'h0, 64'hFFFF_FFFF_8765_4321, 1, 0);
    chk("lwu_rdata", last_rdata, 64'h0000_0000_FFFF_FFFF);

    cur_tag = "ld_lane5";
    do_mem(1'b1, 2'd3, 1'b0, 64'h0000_1005, 64'h0, 64'h1122_3344_5566_7788, 0, 2);
    chk("ld5_rdata", last_rdata, 64'h0000_0000_0011_2233);

    cur_tag = "lh_lane7";
    do_mem(1'b1, 2'd1, 1'b0, 64'h0000_2007, 64'h0, 64'h80FF_FFFF_FFFF_FFFF, 0, 1);
    chk("lh7_rdata", last_rdata, 64'h0000_0000_0000_0080);

    cur_tag = "rv_last_wait";
    do_mem(1'b1, 2'd2, 1'b0, 64'h0000_3000, 64'h0, 64'h0000_0000_8000_0001, 0, TO);
    chk("edge_rfwe", last_rfwe, 1'b1);
    chk("edge_rdata", last_rdata, 64'hFFFF_FFFF_8000_0001);
    chk("edge_timeout", bus_timeout, 1'b0);

    cur_tag = "timeout";
    do_mem(1'b1, 2'd3, 1'b0, 64'h0000_4000, 64'h0, 64'hAAAA_AAAA_AAAA_AAAA, 1, 99);
    chk("to_flag", bus_timeout, 1'b1);
    chk("to_rfwe", last_rfwe, 1'b0);
    chk("to_rdata", last_rdata, 64'h0);

    cur_tag = "rst_wait";
    io.ex_valid = 1'b1; io.ex_mem_re = 1'b1; io.ex_mem_we = 1'b0; io.ex_mem_size = 2'd3;
    io.ex_alu_result = 64'h0000_5000; io.ex_rf_we = 1'b1;
    next_cycle();
    io.dbus_gnt = 1'b1;
    next_cycle();
    io.dbus_gnt = 1'b0;
    @(negedge clk);
    chk("wait_stall", io.mem_stall, 1'b1);
    chk("wait_req", io.dbus_req, 1'b0);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    bto_model = 1'b0;
    io.ex_valid = 1'b0;
    io.dbus_rvalid = 1'b1;
    io.dbus_rdata = 64'h1357_9BDF_2468_ACE0;
    @(negedge clk);
    chk("post_rst_valid", io.mem_valid, 1'b0);
    chk("post_rst_stall", io.mem_stall, 1'b0);
    chk("post_rst_req", io.dbus_req, 1'b0);
    chk("post_rst_pc", io.mem_pc, RESET_PC);
    chk("post_rst_timeout", bus_timeout, 1'b0);
    next_cycle();
    io.dbus_rvalid = 1'b0;
    @(negedge clk);
    chk("late_rv_valid", io.mem_valid, 1'b0);
    chk("late_rv_stall", io.mem_stall, 1'b0);
    $display("txn rst_wait: reset during WAIT, late rvalid ignored");
    next_cycle();
    clear_inputs();

    for (int t = 0; t < 40; t++) begin
      logic        ld  = 1'($urandom);
      logic [1:0]  sz  = 2'($urandom);
      logic        un  = 1'($urandom);
      logic [63:0] a   = {$urandom, $urandom};
      logic [63:0] wd  = {$urandom, $urandom};
      logic [63:0] rd  = {$urandom, $urandom};
      int          gd  = $urandom_range(0, 2);
      int          rvd = $urandom_range(0, 5);
`ifdef MISALIGN_TRAP_EN
      a[2:0] = a[2:0] & ~(3'((1 << sz) - 1));
`endif
      cur_tag = $sformatf("rand%0d", t);
      do_mem(ld, sz, un, a, wd, rd, gd, rvd);
    end

`ifdef MISALIGN_TRAP_EN
    cur_tag = "misalign";
    io.ex_valid = 1'b1; io.ex_mem_re = 1'b1; io.ex_mem_we = 1'b0; io.ex_mem_size = 2'd2;
    io.ex_alu_result = 64'h2; io.ex_rf_we = 1'b1;
    @(negedge clk);
    chk("mis_accept_req", io.dbus_req, 1'b0);
    chk("mis_accept_stall", io.mem_stall, 1'b1);
    next_cycle();
    @(negedge clk);
    chk("mis_flag", mem_misalign, 1'b1);
    chk("mis_valid", io.mem_valid, 1'b1);
    chk("mis_rfwe", io.mem_rf_we, 1'b0);
    chk("mis_rdata", io.mem_rdata, 64'h0);
    chk("mis_req", io.dbus_req, 1'b0);
    $display("txn misalign: LW addr 0x2 trapped");
    next_cycle();
    io.ex_valid = 1'b0;
    @(negedge clk);
    chk("mis_clear", mem_misalign, 1'b0);
    next_cycle();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
